// File: rtl/fsic_io_serdes_link_ctrl.sv
// Serial IO link bring-up: settle, train on pTRAIN_PATTERN, lock or fail; all outputs registered (1 ioclk after decision), no backpressure.
// `FSIC_SERDES_AUTO_RETRAIN_EN adds up to pMAX_RETRY automatic retrains through a 2-cycle RESTART state.
module fsic_io_serdes_link_ctrl #(
    parameter int                    pCLK_RATIO     = 4,
    parameter logic [pCLK_RATIO-1:0] pTRAIN_PATTERN = 4'hA,
    parameter int                    pSETTLE        = 16,
    parameter int                    pLOCK_CNT      = 8,
    parameter int                    pTIMEOUT       = 256,
    parameter int                    pMAX_RETRY     = 3
) (
    input  logic                  ioclk,
    input  logic                  axis_rst_n,
    input  logic                  link_req,
    input  logic [pCLK_RATIO-1:0] rx_word,
    input  logic                  rx_word_stb,
    output logic                  rxen,
    output logic                  txen,
    output logic                  tx_train,
    output logic                  link_up,
    output logic                  link_fail,
    output logic [1:0]            retry_cnt
);

    localparam int TMO_W   = $clog2(pTIMEOUT + 1);
    localparam int MATCH_W = $clog2(pLOCK_CNT + 1);

    localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(pTIMEOUT - 1);
    localparam logic [TMO_W-1:0]   SETTLE_LAST = TMO_W'(pSETTLE - 1);
    localparam logic [TMO_W-1:0]   TMO_ONE     = TMO_W'(1);
    localparam logic [MATCH_W-1:0] LOCK_C      = MATCH_W'(pLOCK_CNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE   = MATCH_W'(1);

`ifdef FSIC_SERDES_AUTO_RETRAIN_EN
    localparam logic [1:0] MAX_RETRY_C = 2'(pMAX_RETRY);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        TRAIN   = 3'd2,
        LOCKED  = 3'd3,
        FAIL    = 3'd4,
        RESTART = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        TRAIN   = 3'd2,
        LOCKED  = 3'd3,
        FAIL    = 3'd4
    } state_t;
`endif

    state_t               state_q, state_d;
    state_t               tmo_state;
    logic [TMO_W-1:0]     tmo_q, tmo_d, tmo_inc;
    logic [MATCH_W-1:0]   match_q, match_d, match_inc;
    logic [1:0]           retry_q, retry_d;
    logic                 tmo_hit, word_ok;
    logic                 rxen_q, rxen_d;
    logic                 txen_q, txen_d;
    logic                 tx_train_q, tx_train_d;
    logic                 link_up_q, link_up_d;
    logic                 link_fail_q, link_fail_d;
`ifdef FSIC_SERDES_AUTO_RETRAIN_EN
    logic                 rs_q, rs_d;
`endif

    always_ff @(posedge ioclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            match_q     <= '0;
            retry_q     <= '0;
            rxen_q      <= 1'b0;
            txen_q      <= 1'b0;
            tx_train_q  <= 1'b0;
            link_up_q   <= 1'b0;
            link_fail_q <= 1'b0;
`ifdef FSIC_SERDES_AUTO_RETRAIN_EN
            rs_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            match_q     <= match_d;
            retry_q     <= retry_d;
            rxen_q      <= rxen_d;
            txen_q      <= txen_d;
            tx_train_q  <= tx_train_d;
            link_up_q   <= link_up_d;
            link_fail_q <= link_fail_d;
`ifdef FSIC_SERDES_AUTO_RETRAIN_EN
            rs_q        <= rs_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        match_d     = match_q;
        retry_d     = retry_q;
        rxen_d      = 1'b0;
        txen_d      = 1'b0;
        tx_train_d  = 1'b0;
        link_up_d   = 1'b0;
        link_fail_d = 1'b0;
`ifdef FSIC_SERDES_AUTO_RETRAIN_EN
        rs_d        = 1'b0;
`endif
        tmo_hit   = (tmo_q == TMO_LAST);
        tmo_inc   = (tmo_q == '1) ? tmo_q : tmo_q + TMO_ONE;
        match_inc = (match_q == '1) ? match_q : match_q + MATCH_ONE;
        word_ok   = rx_word_stb && (rx_word == pTRAIN_PATTERN);

`ifdef FSIC_SERDES_AUTO_RETRAIN_EN
        tmo_state = (retry_q < MAX_RETRY_C) ? RESTART : FAIL;
`else
        tmo_state = FAIL;
`endif

        // Dropping the request overrides every state; retry_cnt is kept for inspection.
        if (!link_req) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    tmo_d   = '0;
                    match_d = '0;
                    retry_d = '0;
                end
                SETTLE: begin
                    if (tmo_hit) begin
                        state_d = tmo_state;
                    end else begin
                        tmo_d = tmo_inc;
                        if (tmo_q == SETTLE_LAST) state_d = TRAIN;
                    end
                end
                TRAIN: begin
                    if (rx_word_stb) match_d = word_ok ? match_inc : '0;
                    // Lock is checked before timeout so a lock on the last cycle wins.
                    if (word_ok && (match_inc == LOCK_C)) begin
                        state_d = LOCKED;
                    end else if (tmo_hit) begin
                        state_d = tmo_state;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
`ifdef FSIC_SERDES_AUTO_RETRAIN_EN
                RESTART: begin
                    rs_d = 1'b1;
                    if (rs_q) begin
                        state_d = SETTLE;
                        rs_d    = 1'b0;
                        retry_d = retry_q + 2'd1;
                        tmo_d   = '0;
                        match_d = '0;
                    end
                end
`endif
                default: ;
            endcase
        end

        case (state_d)
            SETTLE, TRAIN: begin
                rxen_d     = 1'b1;
                txen_d     = 1'b1;
                tx_train_d = 1'b1;
            end
            LOCKED: begin
                rxen_d    = 1'b1;
                txen_d    = 1'b1;
                link_up_d = 1'b1;
            end
            FAIL: link_fail_d = 1'b1;
`ifdef FSIC_SERDES_AUTO_RETRAIN_EN
            // RX is dropped to force the receiver to re-align; TX keeps sending the pattern.
            RESTART: begin
                txen_d     = 1'b1;
                tx_train_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign rxen      = rxen_q;
    assign txen      = txen_q;
    assign tx_train  = tx_train_q;
    assign link_up   = link_up_q;
    assign link_fail = link_fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_fsic_io_serdes_link_ctrl.sv
// Bench for fsic_io_serdes_link_ctrl: table of bring-up scenarios plus reset and retrain sequences.
// Expected outputs are pushed per edge to a scoreboard queue and popped after each edge.
module tb_fsic_io_serdes_link_ctrl;

    logic       ioclk = 1'b0;
    logic       axis_rst_n;
    logic       link_req;
    logic [3:0] rx_word;
    logic       rx_word_stb;
    logic       rxen, txen, tx_train, link_up, link_fail;
    logic [1:0] retry_cnt;

    always #5 ioclk = ~ioclk;

    fsic_io_serdes_link_ctrl dut (
        .ioclk       (ioclk),
        .axis_rst_n  (axis_rst_n),
        .link_req    (link_req),
        .rx_word     (rx_word),
        .rx_word_stb (rx_word_stb),
        .rxen        (rxen),
        .txen        (txen),
        .tx_train    (tx_train),
        .link_up     (link_up),
        .link_fail   (link_fail),
        .retry_cnt   (retry_cnt)
    );

    // {rxen, txen, tx_train, link_up, link_fail, retry_cnt}
    typedef struct packed {
        logic       rxen;
        logic       txen;
        logic       train;
        logic       up;
        logic       fail;
        logic [1:0] retry;
    } out_t;

    typedef struct {
        string      name;
        int         first;   // edge that samples the first strobe; strobes every 4 edges after
        int         bad_n;   // index (from 1) of the strobe carrying bad_val, 0 = none
        logic [3:0] bad_val;
        logic [3:0] dflt;
        int         lock_e;  // edge at which link_up must appear, 0 = never
        int         fail_e;  // edge at which link_fail must appear, 0 = never
        int         n;       // edges to run with link_req high
    } row_t;

    localparam out_t O_IDLE  = 7'b0000000;
    localparam out_t O_TRAIN = 7'b1110000;
    localparam out_t O_LOCK  = 7'b1101000;
    localparam out_t O_FAIL  = 7'b0000100;

    out_t q[$];
    row_t rows[$];
    int   total = 0;
    int   bad   = 0;

    function automatic row_t mkrow(input string nm, input int first, input int bad_n,
                                   input logic [3:0] bad_val, input logic [3:0] dflt,
                                   input int lock_e, input int fail_e, input int n);
        row_t r;
        r.name = nm; r.first = first; r.bad_n = bad_n; r.bad_val = bad_val;
        r.dflt = dflt; r.lock_e = lock_e; r.fail_e = fail_e; r.n = n;
        return r;
    endfunction

    function automatic out_t mk(input logic [4:0] f, input logic [1:0] r);
        return out_t'({f, r});
    endfunction

    task automatic tick();
        @(posedge ioclk);
        #1;
    endtask

    task automatic check_out(input string nm, input int k);
        out_t e, g;
        g = out_t'({rxen, txen, tx_train, link_up, link_fail, retry_cnt});
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL %s edge=%0d scoreboard empty, got=%b", nm, k, g);
        end else begin
            e = q.pop_front();
            if (g !== e) begin
                bad++;
                $display("FAIL %s edge=%0d got=%b want=%b (rxen txen train up fail retry[1:0])",
                         nm, k, g, e);
            end
        end
    endtask

    task automatic run_case(input row_t r, input bit drop);
        int j;
        link_req = 1'b1;
        for (int k = 1; k <= r.n; k++) begin
            j = k - r.first;
            if (k >= r.first && (j % 4) == 0) begin
                rx_word_stb = 1'b1;
                rx_word     = ((j / 4 + 1) == r.bad_n) ? r.bad_val : r.dflt;
            end else begin
                rx_word_stb = 1'b0;
                rx_word     = 4'h0;
            end
            if (r.fail_e != 0 && k >= r.fail_e)      q.push_back(O_FAIL);
            else if (r.lock_e != 0 && k >= r.lock_e) q.push_back(O_LOCK);
            else                                     q.push_back(O_TRAIN);
            tick();
            check_out(r.name, k);
        end
        rx_word_stb = 1'b0;
        rx_word     = 4'h0;
        if (drop) begin
            link_req = 1'b0;
            q.push_back(O_IDLE);
            tick();
            check_out({r.name, "_drop"}, r.n + 1);
            q.push_back(O_IDLE);
            tick();
            check_out({r.name, "_idle"}, r.n + 2);
        end
    endtask

    initial begin
        row_t part;

        rows.push_back(mkrow("lock_clean",     5,  0, 4'h0, 4'hA, 49,  0,   60));
        rows.push_back(mkrow("bad_6th_word",   5, 10, 4'h5, 4'hA, 73,  0,   85));
        rows.push_back(mkrow("bad_first_word", 5,  5, 4'h0, 4'hA, 53,  0,   60));
        rows.push_back(mkrow("bad_in_settle",  5,  4, 4'h5, 4'hA, 49,  0,   60));
        rows.push_back(mkrow("bad_8th_word",   5, 12, 4'h3, 4'hA, 81,  0,   90));
        rows.push_back(mkrow("lock_last_cyc", 229, 0, 4'h0, 4'hA, 257, 0,  262));
`ifndef FSIC_SERDES_AUTO_RETRAIN_EN
        rows.push_back(mkrow("lock_too_late", 233, 0, 4'h0, 4'hA, 0, 257,  262));
        rows.push_back(mkrow("const_zero",      1, 0, 4'h0, 4'h0, 0, 257,  262));
`endif

        axis_rst_n  = 1'b0;
        link_req    = 1'b0;
        rx_word     = 4'h0;
        rx_word_stb = 1'b0;

        repeat (3) tick();
        q.push_back(O_IDLE);
        check_out("reset_state", 0);
        link_req = 1'b1;
        q.push_back(O_IDLE);
        tick();
        check_out("reset_ignores_req", 0);
        link_req   = 1'b0;
        axis_rst_n = 1'b1;
        q.push_back(O_IDLE);
        tick();
        check_out("idle_after_release", 0);

        foreach (rows[i]) run_case(rows[i], 1'b1);

        // Reset asserted between edges while training must clear outputs without a clock.
        part      = rows[0];
        part.name = "pre_reset_train";
        part.n    = 30;
        run_case(part, 1'b0);
        #2 axis_rst_n = 1'b0;
        #1;
        q.push_back(O_IDLE);
        check_out("async_reset", 0);
        q.push_back(O_IDLE);
        tick();
        check_out("reset_held", 0);
        axis_rst_n = 1'b1;
        q.push_back(O_IDLE);
        #1;
        check_out("post_release", 0);
        part      = rows[0];
        part.name = "retrain_after_reset";
        run_case(part, 1'b1);

`ifdef FSIC_SERDES_AUTO_RETRAIN_EN
        // Constant bad data: three RESTART pairs (rxen low) with retry 0..2, then FAIL at retry 3.
        link_req = 1'b1;
        for (int k = 1; k <= 1035; k++) begin
            int a, p;
            a = (k - 1) / 258;
            p = (k - 1) % 258;
            if (k >= 1031)    q.push_back(mk(5'b00001, 2'd3));
            else if (p < 256) q.push_back(mk(5'b11100, 2'(a)));
            else              q.push_back(mk(5'b01100, 2'(a)));
            tick();
            check_out("retrain_seq", k);
        end
        link_req = 1'b0;
        q.push_back(mk(5'b00000, 2'd3));
        tick();
        check_out("retrain_drop", 1036);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsic_io_serdes_link_ctrl.md
FSIC_IO_SERDES_LINK_CTRL -- requirements
Module: fsic_io_serdes_link_ctrl

Interface
REQ-001 SHALL have parameter pCLK_RATIO, default 4: width of the deserialized RX word.
REQ-002 SHALL have parameter pTRAIN_PATTERN, default 4'hA: expected training word.
REQ-003 SHALL have parameter pSETTLE, default 16: ioclk cycles to wait after enable before checking words.
REQ-004 SHALL have parameter pLOCK_CNT, default 8: consecutive matching words needed to lock.
REQ-005 SHALL have parameter pTIMEOUT, default 256: ioclk cycles allowed in SETTLE+TRAIN.
REQ-006 SHALL have parameter pMAX_RETRY, default 3: retrain attempts; used only with the macro.
REQ-007 SHALL have port ioclk, input, 1: controller clock.
REQ-008 SHALL have port axis_rst_n, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port link_req, input, 1: level; 1 requests link bring-up, 0 tears the link down.
REQ-010 SHALL have port rx_word, input, pCLK_RATIO: deserialized word from the RX lane.
REQ-011 SHALL have port rx_word_stb, input, 1: one-cycle pulse, rx_word is new.
REQ-012 SHALL have port rxen, output, 1: RX lane enable.
REQ-013 SHALL have port txen, output, 1: TX lane enable.
REQ-014 SHALL have port tx_train, output, 1: 1 makes the TX lane send pTRAIN_PATTERN.
REQ-015 SHALL have port link_up, output, 1: link locked.
REQ-016 SHALL have port link_fail, output, 1: bring-up failed.
REQ-017 SHALL have port retry_cnt, output, 2: attempts used.

Function
REQ-018 SHALL implement an FSM with states IDLE, SETTLE, TRAIN, LOCKED, FAIL and RESTART; all outputs SHALL be registered.
REQ-019 In IDLE with link_req=1, the FSM SHALL enter SETTLE and set rxen=txen=tx_train=1 on the next edge; it SHALL clear the timeout counter, the match counter and retry_cnt.
REQ-020 SETTLE SHALL last exactly pSETTLE cycles, ignore rx_word_stb, then go to TRAIN.
REQ-021 In TRAIN, on each rx_word_stb: rx_word==pTRAIN_PATTERN increments match_cnt; any mismatch clears it to 0; no strobe holds it.
REQ-022 When a strobed match brings match_cnt to pLOCK_CNT, the FSM SHALL enter LOCKED on that edge: link_up=1 and tx_train=0; rxen and txen stay 1.
REQ-023 The timeout counter SHALL count every cycle in SETTLE and TRAIN; at pTIMEOUT-1 without lock, the next state SHALL be FAIL (macro absent) or the retry path (REQ-031).
REQ-024 If lock and timeout occur on the same cycle, lock SHALL win.
REQ-025 In FAIL: link_fail=1, rxen=txen=tx_train=0, link_up=0; FAIL SHALL be held until link_req=0.
REQ-026 link_req=0 in any state SHALL move the FSM to IDLE on the next edge: all enables, link_up and link_fail 0; retry_cnt held.
REQ-027 LOCKED SHALL persist while link_req=1; rx_word_stb SHALL be ignored.
REQ-028 match_cnt and the timeout counter SHALL saturate and never wrap.

Reset
REQ-029 While axis_rst_n=0: state IDLE; rxen, txen, tx_train, link_up, link_fail = 0; retry_cnt, match_cnt and the timeout counter = 0.
REQ-030 Reset asserted mid-training SHALL take effect immediately without waiting for ioclk; after release, the FSM SHALL restart from IDLE and sample link_req again.

Configuration
REQ-031 With FSIC_SERDES_AUTO_RETRAIN_EN defined: on timeout with retry_cnt<pMAX_RETRY, the FSM SHALL enter RESTART for exactly 2 cycles with rxen=0, then enter SETTLE with retry_cnt+1, counters cleared, rxen=1. At retry_cnt==pMAX_RETRY it SHALL enter FAIL.
REQ-032 Without FSIC_SERDES_AUTO_RETRAIN_EN: RESTART SHALL not exist, a timeout SHALL always go to FAIL, and retry_cnt SHALL stay 0.

Verification
REQ-033 Default params, link_req=1, strobe every 4 cycles with 4'hA -> link_up=1 one edge after the 8th matching strobe after SETTLE; tx_train=0 at the same time.
REQ-034 Same stimulus with 4'h5 injected as the 6th word -> match_cnt resets; lock only after 8 further consecutive 4'hA words.
REQ-035 Constant 4'h0, macro off -> link_fail=1 at cycle 257 after link_req; rxen=0; link_req low -> IDLE next edge.
REQ-036 Constant 4'h0, macro on -> 3 RESTART pulses with rxen=0 for 2 cycles each, retry_cnt 1..3, then FAIL.
REQ-037 axis_rst_n pulsed low during TRAIN -> all outputs 0 asynchronously; link_req still 1 -> SETTLE re-entered one edge after release.
REQ-038 8th match strobe on the final timeout cycle -> LOCKED, not FAIL.
